// File: rtl/opq_op_issuer.sv
// Single-op sequencer for the op-centric queue: accepts an op, bounds-checks it
// against a local occupancy count, drives one queue req until cpl or timeout, returns a response.
`ifndef TOP_DEPTH
`define TOP_DEPTH 4
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 8
`endif

module opq_op_issuer #(
   parameter int p_depth     = `TOP_DEPTH,
   parameter int p_ptrwidth  = $clog2(p_depth),
   parameter int p_chanwidth = `TOP_CHANWIDTH,
   parameter int p_timeout   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   op_val,
   output logic                   op_rdy,
   input  logic [2:0]             op_type,
   input  logic [p_ptrwidth-1:0]  op_tag,
   input  logic [p_chanwidth-1:0] op_data,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic [2:0]             resp_type,
   output logic [1:0]             resp_status,
   output logic [p_ptrwidth-1:0]  resp_tag,
   output logic [p_chanwidth-1:0] resp_data,
   output logic [5:0]             q_req,
   input  logic [5:0]             q_cpl,
   output logic [p_ptrwidth-1:0]  q_tag,
   output logic [p_chanwidth-1:0] q_data,
   input  logic [p_ptrwidth-1:0]  q_enq_back_tag,
   input  logic [p_ptrwidth-1:0]  q_enq_front_tag,
   input  logic [p_chanwidth-1:0] q_deq_front_data,
   input  logic [p_chanwidth-1:0] q_deq_back_data,
   output logic [p_ptrwidth:0]    count,
   output logic                   proto_err,
   output logic [1:0]             dbg_state
);

   // Handshakes: a transfer happens on a rising edge where val and rdy are both high;
   // val holds its payload until that edge and rdy never depends combinationally on val.
   typedef enum logic [1:0] {st_idle = 2'd0, st_issue = 2'd1, st_resp = 2'd2} state_t;

   localparam int tmo_w = (p_timeout > 1) ? $clog2(p_timeout) : 1;
   localparam logic [tmo_w-1:0] tmo_last = tmo_w'((p_timeout > 0) ? p_timeout - 1 : 0);
   localparam logic [p_ptrwidth:0] full_count = (p_ptrwidth + 1)'(p_depth);

   state_t                   state, state_nxt;
   logic [2:0]               type_r;
   logic [p_ptrwidth-1:0]    tag_r;
   logic [p_chanwidth-1:0]   data_r;
   logic [tmo_w-1:0]         tmo_cnt;
   logic                     accept, illegal, is_enq, is_deq, reject, cpl_hit, tmo_hit;

   assign accept  = op_val && (state == st_idle);
   assign illegal = (op_type > 3'd5);
   assign is_enq  = (op_type == 3'd0) || (op_type == 3'd1);
   assign is_deq  = (op_type >= 3'd2) && (op_type <= 3'd5);
   assign reject  = (is_enq && (count == full_count)) || (is_deq && (count == '0));
   assign cpl_hit = |(q_cpl & q_req);
   assign tmo_hit = (p_timeout != 0) && (tmo_cnt == tmo_last) && !cpl_hit;

   always_ff @(posedge clk) begin
      if (rst) state <= st_idle;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:  if (accept) state_nxt = (illegal || reject) ? st_resp : st_issue;
         st_issue: if (cpl_hit || tmo_hit) state_nxt = st_resp;
         st_resp:  if (resp_rdy) state_nxt = st_idle;
         default:  state_nxt = st_idle;
      endcase
   end

   always_comb begin
      op_rdy    = (state == st_idle);
      resp_val  = (state == st_resp);
      dbg_state = state;
      q_req     = '0;
      for (int i = 0; i < 6; i++) q_req[i] = (state == st_issue) && (type_r == 3'(i));
      q_tag     = tag_r;
      q_data    = data_r;
   end

   // Op latch, response capture, occupancy and timeout bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         type_r      <= '0;
         tag_r       <= '0;
         data_r      <= '0;
         tmo_cnt     <= '0;
         resp_type   <= '0;
         resp_status <= '0;
         resp_tag    <= '0;
         resp_data   <= '0;
         count       <= '0;
         proto_err   <= 1'b0;
      end else begin
         if ((q_cpl & ~q_req) != 6'b0) proto_err <= 1'b1;
         case (state)
            st_idle: if (accept) begin
               type_r      <= op_type;
               tag_r       <= op_tag;
               data_r      <= op_data;
               tmo_cnt     <= '0;
               resp_type   <= op_type;
               resp_tag    <= '0;
               resp_data   <= '0;
               resp_status <= illegal ? 2'b10 : (reject ? 2'b01 : 2'b00);
            end
            st_issue: begin
               if (cpl_hit) begin
                  resp_status <= 2'b00;
                  case (type_r)
                     3'd0: begin resp_tag  <= q_enq_back_tag;   count <= count + 1'b1; end
                     3'd1: begin resp_tag  <= q_enq_front_tag;  count <= count + 1'b1; end
                     3'd2: begin resp_data <= q_deq_front_data; count <= count - 1'b1; end
                     3'd3: begin resp_data <= q_deq_back_data;  count <= count - 1'b1; end
                     3'd5: count <= count - 1'b1;
                     default: ;
                  endcase
               end else if (tmo_hit) begin
                  resp_status <= 2'b11;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
